// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: PC/flush inputs, IF/ID valid/ready handshake and the
// byte-wide memory controller port. master = fetch stage, slave = its environment.
interface if_fetch_if;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        inst_ready_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        stallreq_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [7:0]  mem_rdata_i;

    modport master (
        input  pc_i, flush_i, inst_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output inst_valid_o, inst_o, inst_addr_o, stallreq_o, mem_req_o, mem_addr_o
    );

    modport slave (
        output pc_i, flush_i, inst_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  inst_valid_o, inst_o, inst_addr_o, stallreq_o, mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: direct-mapped one-word I-cache in front of a byte-wide
// memory port, with valid/ready output handshake and flush/drain on redirect.
//
// state   | meaning
// IDLE    | no instruction held; every non-flush cycle is a lookup
// FETCH   | miss in progress; requesting / collecting 4 bytes
// VALID   | inst_o held until accepted; transfer cycle doubles as lookup
// DRAIN   | fetch aborted; swallowing rvalids of already-granted bytes
module if_fetch #(
    parameter int IDX_W = 6
) (
    input  logic   clk,
    input  logic   rst,
    if_fetch_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;
    localparam int N_ENT = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic [1:0]       state;
    logic [31:0]      cur_pc;
    logic [2:0]       req_cnt;
    logic [1:0]       rv_cnt;
    logic [2:0]       out_cnt;
    logic [2:0]       out_nxt;
    logic [23:0]      byte_buf;
    logic             inst_valid;
    logic [31:0]      inst;
    logic [31:0]      inst_addr;

    logic [N_ENT-1:0] c_valid;
    logic [TAG_W-1:0] c_tag  [N_ENT];
    logic [31:0]      c_data [N_ENT];

    logic [31:0]      pc_al;
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             hit;
    logic             lookup;
    logic             mem_req;
    logic             gnt_ok;
    logic             rv_ok;
    logic             c_wr;

    always_comb begin
        pc_al   = bus.pc_i & ~32'h3;
        lk_idx  = pc_al[IDX_W+1:2];
        wr_idx  = cur_pc[IDX_W+1:2];
        hit     = c_valid[lk_idx] && (c_tag[lk_idx] == pc_al[31:IDX_W+2]);
        lookup  = !bus.flush_i &&
                  (state == S_IDLE || (state == S_VALID && bus.inst_ready_i));
        mem_req = (state == S_FETCH) && !req_cnt[2];
        gnt_ok  = mem_req && bus.mem_gnt_i;
        // An rvalid with nothing outstanding is stray and must not count.
        rv_ok   = bus.mem_rvalid_i && (out_cnt != 3'd0);
        out_nxt = out_cnt + {2'b00, gnt_ok} - {2'b00, rv_ok};
        c_wr    = !rst && (state == S_FETCH) && !bus.flush_i && rv_ok && (rv_cnt == 2'd3);
    end

    assign bus.mem_req_o    = mem_req;
    assign bus.mem_addr_o   = mem_req ? (cur_pc + {29'd0, req_cnt}) : 32'd0;
    assign bus.stallreq_o   = (state == S_FETCH) || (state == S_DRAIN);
    assign bus.inst_valid_o = inst_valid;
    assign bus.inst_o       = inst;
    assign bus.inst_addr_o  = inst_addr;

    always_ff @(posedge clk) begin
        if (c_wr) begin
            c_tag[wr_idx]  <= cur_pc[31:IDX_W+2];
            c_data[wr_idx] <= {bus.mem_rdata_i, byte_buf};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cur_pc     <= 32'd0;
            req_cnt    <= 3'd0;
            rv_cnt     <= 2'd0;
            out_cnt    <= 3'd0;
            byte_buf   <= 24'd0;
            inst_valid <= 1'b0;
            inst       <= 32'd0;
            inst_addr  <= 32'd0;
            c_valid    <= '0;
        end else begin
            out_cnt <= out_nxt;
            if (c_wr)
                c_valid[wr_idx] <= 1'b1;
            case (state)
                S_IDLE, S_VALID: begin
                    if (bus.flush_i) begin
                        state      <= S_IDLE;
                        inst_valid <= 1'b0;
                    end else if (lookup) begin
                        if (hit) begin
                            state      <= S_VALID;
                            inst_valid <= 1'b1;
                            inst       <= c_data[lk_idx];
                            inst_addr  <= pc_al;
                        end else begin
                            state      <= S_FETCH;
                            inst_valid <= 1'b0;
                            cur_pc     <= pc_al;
                            req_cnt    <= 3'd0;
                            rv_cnt     <= 2'd0;
                        end
                    end
                end
                S_FETCH: begin
                    if (gnt_ok)
                        req_cnt <= req_cnt + 3'd1;
                    if (bus.flush_i) begin
                        state <= (out_nxt != 3'd0) ? S_DRAIN : S_IDLE;
                    end else if (rv_ok) begin
                        rv_cnt <= rv_cnt + 2'd1;
                        case (rv_cnt)
                            2'd0: byte_buf[7:0]   <= bus.mem_rdata_i;
                            2'd1: byte_buf[15:8]  <= bus.mem_rdata_i;
                            2'd2: byte_buf[23:16] <= bus.mem_rdata_i;
                            default: begin
                                state      <= S_VALID;
                                inst_valid <= 1'b1;
                                inst       <= {bus.mem_rdata_i, byte_buf};
                                inst_addr  <= cur_pc;
                            end
                        endcase
                    end
                end
                S_DRAIN: begin
                    if (out_nxt == 3'd0)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: a transaction-level cache/memory model predicts
// hit/miss, instruction word, byte address order and latency per fetch.
module tb_if_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    if_fetch_if bus ();
    if_fetch #(.IDX_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // model state
    bit          m_valid [64];
    logic [31:0] m_line  [64];
    logic [31:0] gnt_q [$];
    int          gnt_total = 0;
    int          gnt_mode  = 0;
    bit          in_valid  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] t0 [4];
        t0 = '{8'h13, 8'h05, 8'h00, 8'h00};
        if (a < 32'd4) return t0[a[1:0]];
        return (a[7:0] * 8'd29) ^ a[15:8] ^ 8'h5a;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 3), mem_byte(a + 2), mem_byte(a + 1), mem_byte(a)};
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        logic [31:0] pa;
        pa = pc & ~32'h3;
        return m_valid[pa[7:2]] && (m_line[pa[7:2]] == pa);
    endfunction

    // Memory controller: grants chosen per mode, byte returned one cycle after grant,
    // plus occasional stray rvalids when nothing is outstanding.
    initial begin
        bit          pend = 1'b0;
        bit          alt  = 1'b0;
        logic [31:0] pend_addr = 32'd0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 8'd0;
        forever begin
            @(negedge clk);
            bus.mem_rvalid_i = pend;
            bus.mem_rdata_i  = pend ? mem_byte(pend_addr) : 8'($urandom);
            if (!pend && gnt_mode == 2 && $urandom_range(3) == 0)
                bus.mem_rvalid_i = 1'b1;
            if (!bus.mem_req_o) alt = 1'b0;
            case (gnt_mode)
                0:       bus.mem_gnt_i = 1'b1;
                1:       bus.mem_gnt_i = alt;
                default: bus.mem_gnt_i = 1'($urandom_range(1));
            endcase
            if (bus.mem_req_o) alt = ~alt;
            pend      = bus.mem_req_o && bus.mem_gnt_i;
            pend_addr = bus.mem_addr_o;
            if (pend) begin
                gnt_q.push_back(bus.mem_addr_o);
                gnt_total++;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] pc, input int hold);
        logic [31:0] pa;
        logic [31:0] exp_inst;
        bit          exp_hit;
        int          lat;
        pa       = pc & ~32'h3;
        exp_inst = mem_word(pa);
        exp_hit  = model_hit(pc);
        gnt_q.delete();
        bus.pc_i         = pc;
        bus.inst_ready_i = 1'b1;
        bus.flush_i      = 1'b0;
        lat = 0;
        do begin
            step();
            lat++;
            if (!bus.inst_valid_o) check("stall_in_fetch", {31'd0, bus.stallreq_o}, 32'd1);
        end while (!bus.inst_valid_o && lat < 80);
        bus.inst_ready_i = 1'b0;
        check("valid_timeout", {31'd0, bus.inst_valid_o}, 32'd1);
        check("inst", bus.inst_o, exp_inst);
        check("inst_addr", bus.inst_addr_o, pa);
        check("stall_done", {31'd0, bus.stallreq_o}, 32'd0);
        check("hit", {31'd0, gnt_q.size() == 0}, {31'd0, exp_hit});
        if (exp_hit) begin
            check("hit_latency", lat, 32'd1);
        end else begin
            check("n_bytes", gnt_q.size(), 32'd4);
            for (int k = 0; k < 4 && k < gnt_q.size(); k++)
                check("byte_addr", gnt_q[k], pa + 32'(k));
            if (gnt_mode == 0) check("miss_latency", lat, 32'd6);
            if (gnt_mode == 1) check("miss_latency_alt", lat, 32'd10);
            m_valid[pa[7:2]] = 1'b1;
            m_line[pa[7:2]]  = pa;
        end
        for (int h = 0; h < hold; h++) begin
            bus.pc_i = $urandom;
            step();
            check("hold_valid", {31'd0, bus.inst_valid_o}, 32'd1);
            check("hold_inst", bus.inst_o, exp_inst);
            check("hold_addr", bus.inst_addr_o, pa);
        end
        in_valid = 1'b1;
    endtask

    // Start a miss, abort it after n grants (flush or reset), then wait for quiet.
    task automatic abort_miss(input logic [31:0] pc, input int n, input bit use_rst);
        int g0;
        int t;
        g0 = gnt_total;
        bus.pc_i         = pc;
        bus.inst_ready_i = 1'b1;
        bus.flush_i      = 1'b0;
        t = 0;
        do begin
            step();
            t++;
        end while ((gnt_total - g0) < n && t < 40);
        check("abort_reach", {31'd0, (gnt_total - g0) >= n}, 32'd1);
        check("abort_in_fetch", {31'd0, bus.stallreq_o}, 32'd1);
        if (use_rst) rst = 1'b1;
        else         bus.flush_i = 1'b1;
        bus.inst_ready_i = 1'($urandom_range(1));
        step();
        rst = 1'b0;
        bus.flush_i      = 1'b0;
        bus.inst_ready_i = 1'b0;
        check("abort_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        if (use_rst) begin
            check("rst_req", {31'd0, bus.mem_req_o}, 32'd0);
            check("rst_stall", {31'd0, bus.stallreq_o}, 32'd0);
            check("rst_inst", bus.inst_o, 32'd0);
            check("rst_addr", bus.inst_addr_o, 32'd0);
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        end
        t = 0;
        while (bus.stallreq_o && t < 8) begin
            check("drain_no_req", {31'd0, bus.mem_req_o}, 32'd0);
            step();
            t++;
        end
        check("drain_end", {31'd0, bus.stallreq_o}, 32'd0);
        check("drain_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic flush_valid();
        bus.flush_i      = 1'b1;
        bus.inst_ready_i = 1'($urandom_range(1));
        bus.pc_i         = $urandom;
        step();
        bus.flush_i      = 1'b0;
        bus.inst_ready_i = 1'b0;
        check("flush_valid_drop", {31'd0, bus.inst_valid_o}, 32'd0);
        check("flush_valid_stall", {31'd0, bus.stallreq_o}, 32'd0);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] pool [8];
        logic [31:0] pc;
        int          op;
        pool = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h100, 32'h104, 32'h200, 32'h1000};
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        bus.pc_i = 32'd0;
        bus.flush_i = 1'b0;
        bus.inst_ready_i = 1'b0;
        rst = 1'b1;
        step();
        step();
        check("reset_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        check("reset_inst", bus.inst_o, 32'd0);
        check("reset_addr", bus.inst_addr_o, 32'd0);
        check("reset_req", {31'd0, bus.mem_req_o}, 32'd0);
        check("reset_maddr", bus.mem_addr_o, 32'd0);
        check("reset_stall", {31'd0, bus.stallreq_o}, 32'd0);
        rst = 1'b0;

        gnt_mode = 0;
        do_fetch(32'h0, 0);
        check("first_inst", bus.inst_o, 32'h0000_0513);
        do_fetch(32'h0, 3);
        do_fetch(32'h4, 0);
        do_fetch(32'h100, 0);
        do_fetch(32'h0, 0);
        do_fetch(32'h100, 1);
        abort_miss(32'h40, 2, 1'b0);
        do_fetch(32'h104, 0);
        do_fetch(32'h40, 0);
        flush_valid();
        gnt_mode = 1;
        do_fetch(32'h200, 0);
        do_fetch(32'h300, 2);

        gnt_mode = 2;
        for (int it = 0; it < 60; it++) begin
            pc = ($urandom_range(3) == 0) ? 32'($urandom_range(16'hffff)) : pool[$urandom_range(7)];
            op = $urandom_range(9);
            if (op >= 7 && op <= 8 && !model_hit(pc))
                abort_miss(pc, $urandom_range(3), 1'b0);
            else if (op == 9 && in_valid)
                flush_valid();
            else
                do_fetch(pc, $urandom_range(3));
        end

        gnt_mode = 0;
        do_fetch(32'h0, 0);
        abort_miss(32'h2000, 2, 1'b1);
        do_fetch(32'h0, 0);
        do_fetch(32'h2000, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
